// File: rtl/snake_pkg.sv
// snake_pkg: playfield constants, coordinate/length types and collision FSM states
package snake_pkg;
    localparam int GRID_W     = 32;
    localparam int GRID_H     = 24;
    localparam int COORD_BITS = 6;
    localparam int MAX_LEN    = 64;
    localparam int LEN_BITS   = 7;
    typedef logic [COORD_BITS-1:0] coord_t;
    typedef logic [LEN_BITS-1:0] len_t;
    typedef enum logic [2:0] {S_IDLE, S_WALL, S_SCAN, S_FLUSH, S_DONE} cd_state_e;
endpackage

// File: rtl/seg_compare.sv
// seg_compare: holds the latched head position and flags a body segment landing on it
module seg_compare
    import snake_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [COORD_BITS-1:0] head_x_i,
    input  logic [COORD_BITS-1:0] head_y_i,
    input  logic [COORD_BITS-1:0] seg_x_i,
    input  logic [COORD_BITS-1:0] seg_y_i,
    output logic [COORD_BITS-1:0] head_x_o,
    output logic [COORD_BITS-1:0] head_y_o,
    output logic                  match_o
);
    coord_t hx_q, hy_q;
    always_ff @(posedge clk_i)
        if (rst_i) begin
            hx_q <= '0;
            hy_q <= '0;
        end else if (load_i) begin
            hx_q <= head_x_i;
            hy_q <= head_y_i;
        end
    assign head_x_o = hx_q;
    assign head_y_o = hy_q;
    assign match_o  = {seg_x_i, seg_y_i} == {hx_q, hy_q};
endmodule

// File: rtl/collision_detector.sv
// collision_detector: per-tick wall and self-collision check of the snake head.
// Define WALL_WRAP_EN for a wrapping board where the wall check never hits.
module collision_detector
    import snake_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [COORD_BITS-1:0] headX,
    input  logic [COORD_BITS-1:0] headY,
    input  logic [LEN_BITS-1:0]   snakeLength,
    output logic [LEN_BITS-1:0]   segAddr,
    input  logic [COORD_BITS-1:0] segX,
    input  logic [COORD_BITS-1:0] segY,
    output logic                  busy,
    output logic                  checkDone,
    output logic                  collision
);
    cd_state_e state_q, state_d;
    len_t      len_q, addr_q, addr_d, len_in;
    coord_t    hx, hy;
    logic      busy_q, done_q, coll_q, start, wall_hit, match, hit_set;
    seg_compare u_cmp (
        .clk_i    (clock),
        .rst_i    (reset),
        .load_i   (start),
        .head_x_i (headX),
        .head_y_i (headY),
        .seg_x_i  (segX),
        .seg_y_i  (segY),
        .head_x_o (hx),
        .head_y_o (hy),
        .match_o  (match)
    );
    assign start  = state_q == S_IDLE && tick && !coll_q;
    assign len_in = snakeLength > len_t'(MAX_LEN) ? len_t'(MAX_LEN) : snakeLength;
`ifdef WALL_WRAP_EN
    assign wall_hit = 1'b0;
`else
    assign wall_hit = hx >= coord_t'(GRID_W) || hy >= coord_t'(GRID_H);
`endif
    // segAddr is the address being issued this cycle, so an early hit stops further reads
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hit_set = 1'b0;
        case (state_q)
            S_IDLE:  state_d = start ? S_WALL : S_IDLE;
            S_WALL: begin
                hit_set = wall_hit;
                if (wall_hit || len_q <= len_t'(1)) state_d = S_DONE;
                else begin
                    addr_d  = len_t'(1);
                    state_d = len_q == len_t'(2) ? S_FLUSH : S_SCAN;
                end
            end
            S_SCAN: begin
                hit_set = match;
                if (match) state_d = S_DONE;
                else begin
                    addr_d  = addr_q + len_t'(1);
                    state_d = addr_d == len_q - len_t'(1) ? S_FLUSH : S_SCAN;
                end
            end
            S_FLUSH: begin
                hit_set = match;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clock)
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= state_d != S_IDLE;
            done_q  <= state_q == S_DONE;
            coll_q  <= coll_q | hit_set;
            if (start) len_q <= len_in;
        end
    assign segAddr   = addr_d;
    assign busy      = busy_q;
    assign checkDone = done_q;
    assign collision = coll_q;
endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: directed and random checks against a behavioural collision model
module tb_collision_detector;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [5:0] hx_i = '0, hy_i = '0, seg_x, seg_y;
    logic [6:0] len_i = '0, seg_addr;
    logic       busy, done, coll;
    logic [5:0] ramx [128];
    logic [5:0] ramy [128];
    int         n_checks = 0, n_err = 0;
    bit         m_coll = 0;
    int         m_addr = 0;

    collision_detector dut (
        .clock       (clk),
        .reset       (rst),
        .tick        (tick),
        .headX       (hx_i),
        .headY       (hy_i),
        .snakeLength (len_i),
        .segAddr     (seg_addr),
        .segX        (seg_x),
        .segY        (seg_y),
        .busy        (busy),
        .checkDone   (done),
        .collision   (coll)
    );

    always #5 clk = ~clk;

    // body RAM with one cycle of read latency
    always @(posedge clk) begin
        seg_x <= ramx[seg_addr];
        seg_y <= ramy[seg_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_body();
        for (int i = 0; i < 128; i++) begin
            ramx[i] = 6'd60;
            ramy[i] = 6'd60;
        end
    endtask

    task automatic set_seg(input int i, input int x, input int y);
        ramx[i] = 6'(x);
        ramy[i] = 6'(y);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; tick = 1; hx_i = 6'd40; hy_i = 6'd5; len_i = 7'd4;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_coll", coll, 0);
            check("rst_addr", seg_addr, 0);
        end
        rst = 0; tick = 0;
        m_coll = 0; m_addr = 0;
    endtask

    task automatic run_check(input int hx, input int hy, input int len, input bit retick);
        int lm, k, exp_lat, exp_max, lat, pulses, maxa, budget;
        bit wall;
        lm = len > 64 ? 64 : len;
`ifdef WALL_WRAP_EN
        wall = 0;
`else
        wall = hx >= 32 || hy >= 24;
`endif
        k = 0;
        if (!wall)
            for (int i = 1; i < lm; i++)
                if (k == 0 && int'(ramx[i]) == hx && int'(ramy[i]) == hy) k = i;
        if (m_coll) begin exp_lat = 0; exp_max = m_addr; end
        else if (wall || lm <= 1) begin exp_lat = 3; exp_max = m_addr; end
        else if (k != 0) begin exp_lat = k + 3; exp_max = k; end
        else begin exp_lat = lm + 2; exp_max = lm - 1; end
        budget = lm + 8;
        @(negedge clk);
        tick = 1; hx_i = 6'(hx); hy_i = 6'(hy); len_i = 7'(len);
        @(negedge clk);
        tick = 0;
        lat = 0; pulses = 0; maxa = 0;
        for (int c = 1; c <= budget; c++) begin
            if (done) begin
                pulses++;
                if (lat == 0) lat = c;
            end
            if (int'(seg_addr) > maxa) maxa = int'(seg_addr);
            if (retick) tick = (c == 2);
            @(negedge clk);
        end
        tick = 0;
        m_coll = m_coll | wall | (k != 0);
        m_addr = exp_max;
        check("latency", lat, exp_lat);
        check("pulses", pulses, m_coll && exp_lat == 0 ? 0 : 1);
        check("max_addr", maxa, exp_max);
        check("final_addr", seg_addr, exp_max);
        check("collision", coll, m_coll);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int hx, hy, len, k;
        clear_body();
        do_reset();
        run_check(32, 5, 4, 0);
        do_reset();
        set_seg(1, 9, 10); set_seg(2, 8, 10); set_seg(3, 8, 11); set_seg(4, 9, 11);
        run_check(10, 10, 5, 0);
        set_seg(2, 9, 11);
        run_check(9, 11, 5, 0);
        do_reset();
        clear_body();
        run_check(20, 20, 10, 1);
        run_check(31, 23, 3, 0);
        set_seg(1, 9, 10); set_seg(2, 9, 11); set_seg(3, 8, 11); set_seg(4, 9, 11);
        @(negedge clk);
        tick = 1; hx_i = 6'd9; hy_i = 6'd11; len_i = 7'd5;
        @(negedge clk);
        tick = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_coll", coll, 0);
        check("midrst_addr", seg_addr, 0);
        check("midrst_done", done, 0);
        rst = 0; m_coll = 0; m_addr = 0;
        set_seg(2, 8, 10);
        run_check(10, 10, 5, 0);
        do_reset();
        run_check(32, 5, 1, 0);
        run_check(3, 3, 0, 0);
        for (int it = 0; it < 40; it++) begin
            if (m_coll || $urandom_range(0, 5) == 0) do_reset();
            for (int i = 0; i < 128; i++) set_seg(i, $urandom_range(0, 40), $urandom_range(0, 40));
            hx = $urandom_range(0, 35);
            hy = $urandom_range(0, 27);
            len = $urandom_range(0, 70);
            if (len >= 2 && len <= 64 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, len - 1);
                set_seg(k, hx, hy);
            end
            run_check(hx, hy, len, $urandom_range(0, 3) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
